// File: rtl/demosaic_bilinear.sv
`default_nettype none
// ============================================================================
// Module      : demosaic_bilinear
// Description : Bilinear Bayer demosaic on a 3x3 kernel token stream.
//               Tracks the Bayer site from the token framing, and emits one
//               packed {R,G,B} word per pixel token. Every token, whether a
//               pixel, header or bubble, passes through a fixed 2-stage
//               pipeline, so stream order and gaps are preserved.
// Ports       : clk, resetb (async, active low)
//               dvi/dtypei/kernel_datai/meta_datai : input token
//               enable        : 1 = demosaic, 0 = grey bypass {C,C,C}
//               bayer_pattern : colour of pixel (0,0), latched at FRAME_START
//               dvo/dtypeo/meta_datao/datao : output token, 2 clocks later
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h40
`endif

module demosaic_bilinear #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     dvi,
    input  logic [`DTYPE_WIDTH-1:0]  dtypei,
    input  logic [9*PIXEL_WIDTH-1:0] kernel_datai,
    input  logic [DATA_WIDTH-1:0]    meta_datai,
    input  logic                     enable,
    input  logic [1:0]               bayer_pattern,
    output logic                     dvo,
    output logic [`DTYPE_WIDTH-1:0]  dtypeo,
    output logic [DATA_WIDTH-1:0]    meta_datao,
    output logic [3*PIXEL_WIDTH-1:0] datao
);

    // Four-term sums need two guard bits; two-term sums need one.
    localparam int c_SW4 = PIXEL_WIDTH + 2;
    localparam int c_SW2 = PIXEL_WIDTH + 1;

    logic [PIXEL_WIDTH-1:0] w_k [9];

    for (genvar i = 0; i < 9; i++) begin : g_unpack
        assign w_k[i] = kernel_datai[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    // Kernel taps: k[r][c] at index r*3+c.
    logic w_is_pix;
    logic [1:0] w_site;
    assign w_is_pix = (dtypei & `DTYPE_PIXEL_MASK) != '0;

    // Bayer parity state
    logic       r_row_odd;
    logic       r_col_odd;
    logic [1:0] r_pat;

    assign w_site = r_pat ^ {r_row_odd, r_col_odd};

    // Stage 1 registers
    logic                    r_s1_valid;
    logic [`DTYPE_WIDTH-1:0] r_s1_dtype;
    logic [DATA_WIDTH-1:0]   r_s1_meta;
    logic                    r_s1_pix;
    logic                    r_s1_en;
    logic [1:0]              r_s1_site;
    logic [PIXEL_WIDTH-1:0]  r_s1_c;
    logic [c_SW4-1:0]        r_s1_sum_x;
    logic [c_SW4-1:0]        r_s1_sum_p;
    logic [c_SW2-1:0]        r_s1_sum_we;
    logic [c_SW2-1:0]        r_s1_sum_ns;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_row_odd <= 1'b0;
            r_col_odd <= 1'b0;
            r_pat     <= 2'd0;
        end else if (dvi) begin
            if (dtypei == `DTYPE_FRAME_START) begin
                r_row_odd <= 1'b0;
                r_pat     <= bayer_pattern;
            end
            if (dtypei == `DTYPE_ROW_START) begin
                r_col_odd <= 1'b0;
            end
            if (dtypei == `DTYPE_ROW_END) begin
                r_row_odd <= ~r_row_odd;
            end
            // Site for this pixel was already taken from the old value.
            if (w_is_pix) begin
                r_col_odd <= ~r_col_odd;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_s1_valid  <= 1'b0;
            r_s1_dtype  <= '0;
            r_s1_meta   <= '0;
            r_s1_pix    <= 1'b0;
            r_s1_en     <= 1'b0;
            r_s1_site   <= 2'd0;
            r_s1_c      <= '0;
            r_s1_sum_x  <= '0;
            r_s1_sum_p  <= '0;
            r_s1_sum_we <= '0;
            r_s1_sum_ns <= '0;
        end else begin
            r_s1_valid  <= dvi;
            r_s1_dtype  <= dtypei;
            r_s1_meta   <= meta_datai;
            r_s1_pix    <= dvi & w_is_pix;
            r_s1_en     <= enable;
            r_s1_site   <= w_site;
            r_s1_c      <= w_k[4];
            r_s1_sum_x  <= c_SW4'(w_k[0]) + c_SW4'(w_k[2]) + c_SW4'(w_k[6]) + c_SW4'(w_k[8]);
            r_s1_sum_p  <= c_SW4'(w_k[1]) + c_SW4'(w_k[7]) + c_SW4'(w_k[3]) + c_SW4'(w_k[5]);
            r_s1_sum_we <= c_SW2'(w_k[3]) + c_SW2'(w_k[5]);
            r_s1_sum_ns <= c_SW2'(w_k[1]) + c_SW2'(w_k[7]);
        end
    end

    // Stage 2: round-to-nearest divides; results always fit PIXEL_WIDTH.
    logic [PIXEL_WIDTH-1:0]   w_x;
    logic [PIXEL_WIDTH-1:0]   w_p;
    logic [PIXEL_WIDTH-1:0]   w_we;
    logic [PIXEL_WIDTH-1:0]   w_ns;
    logic [3*PIXEL_WIDTH-1:0] w_rgb;

    assign w_x  = PIXEL_WIDTH'((r_s1_sum_x  + c_SW4'(2)) >> 2);
    assign w_p  = PIXEL_WIDTH'((r_s1_sum_p  + c_SW4'(2)) >> 2);
    assign w_we = PIXEL_WIDTH'((r_s1_sum_we + c_SW2'(1)) >> 1);
    assign w_ns = PIXEL_WIDTH'((r_s1_sum_ns + c_SW2'(1)) >> 1);

    always_comb begin
        w_rgb = '0;
        if (r_s1_pix) begin
            if (!r_s1_en) begin
                w_rgb = {r_s1_c, r_s1_c, r_s1_c};
            end else begin
                case (r_s1_site)
                    2'd0:    w_rgb = {r_s1_c, w_p,    w_x};
                    2'd1:    w_rgb = {w_we,   r_s1_c, w_ns};
                    2'd2:    w_rgb = {w_ns,   r_s1_c, w_we};
                    default: w_rgb = {w_x,    w_p,    r_s1_c};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            datao      <= '0;
        end else begin
            dvo        <= r_s1_valid;
            dtypeo     <= r_s1_dtype;
            meta_datao <= r_s1_meta;
            datao      <= w_rgb;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demosaic_bilinear.sv
`default_nettype none
// ============================================================================
// Module      : tb_demosaic_bilinear
// Description : Directed self-checking bench for demosaic_bilinear. Each step
//               drives one token with its hand-computed expected output; the
//               output is compared two clocks after that token's dvi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demosaic_bilinear;

    localparam logic [7:0] c_FS = 8'h01;
    localparam logic [7:0] c_FE = 8'h02;
    localparam logic [7:0] c_RS = 8'h04;
    localparam logic [7:0] c_RE = 8'h08;
    localparam logic [7:0] c_HD = 8'h10;
    localparam logic [7:0] c_PX = 8'h40;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        dvi = 1'b0;
    logic [7:0]  dtypei = '0;
    logic [89:0] kernel_datai = '0;
    logic [15:0] meta_datai = '0;
    logic        enable = 1'b0;
    logic [1:0]  bayer_pattern = 2'd0;
    logic        dvo;
    logic [7:0]  dtypeo;
    logic [15:0] meta_datao;
    logic [29:0] datao;

    demosaic_bilinear #(.PIXEL_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .kernel_datai (kernel_datai),
        .meta_datai   (meta_datai),
        .enable       (enable),
        .bayer_pattern(bayer_pattern),
        .dvo          (dvo),
        .dtypeo       (dtypeo),
        .meta_datao   (meta_datao),
        .datao        (datao)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        cur_en  = 1'b1;
    logic [1:0]  cur_pat = 2'd0;

    // Expectation for the token driven one step earlier.
    logic        p_armed = 1'b0;
    logic        p_dvo   = 1'b0;
    logic [7:0]  p_dt    = '0;
    logic [15:0] p_meta  = '0;
    logic [29:0] p_data  = '0;
    string       p_tag   = "";

    function automatic logic [89:0] kn(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        int a[9];
        logic [89:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int i = 0; i < 9; i++) r[i*10 +: 10] = 10'(a[i]);
        return r;
    endfunction

    function automatic logic [29:0] rgb(input int r, input int g, input int b);
        return {10'(r), 10'(g), 10'(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] dt, input logic [89:0] k,
                        input logic [15:0] m, input logic [29:0] exp_rgb, input string tag);
        dvi = v; dtypei = dt; kernel_datai = k; meta_datai = m;
        enable = cur_en; bayer_pattern = cur_pat;
        @(posedge clk); #1;
        if (p_armed) begin
            chk({p_tag, ".dvo"},   64'(dvo),        64'(p_dvo));
            chk({p_tag, ".dtype"}, 64'(dtypeo),     64'(p_dt));
            chk({p_tag, ".meta"},  64'(meta_datao), 64'(p_meta));
            chk({p_tag, ".data"},  64'(datao),      64'(p_data));
        end
        p_armed = 1'b1; p_dvo = v; p_dt = dt; p_meta = m; p_data = exp_rgb; p_tag = tag;
    endtask

    task automatic tok(input logic [7:0] dt, input logic [15:0] m, input string tag);
        step(1'b1, dt, '0, m, '0, tag);
    endtask

    task automatic px(input logic [89:0] k, input logic [29:0] e, input string tag);
        step(1'b1, c_PX, k, 16'h0, e, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, '0, 16'h0, '0, tag);
    endtask

    logic [89:0] k_flat, k_19, k_c, k_a, k_r1, k_e1, k_e2, k_max;

    initial begin
        k_flat = kn(512, 512, 512, 512, 512, 512, 512, 512, 512);
        k_19   = kn(1, 2, 3, 4, 5, 6, 7, 8, 9);
        k_c    = kn(0, 2, 3, 4, 5, 6, 7, 8, 20);
        k_a    = kn(0, 0, 0, 20, 7, 40, 0, 10, 0);
        k_r1   = kn(0, 0, 0, 0, 3, 1, 0, 0, 0);
        k_e1   = kn(0, 0, 0, 0, 9, 1, 0, 0, 0);
        k_e2   = kn(0, 0, 0, 0, 9, 2, 0, 0, 0);
        k_max  = kn(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023);

        // Reset state
        @(posedge clk); #1;
        chk("rst.dvo",   64'(dvo),        64'd0);
        chk("rst.dtype", 64'(dtypeo),     64'd0);
        chk("rst.meta",  64'(meta_datao), 64'd0);
        chk("rst.data",  64'(datao),      64'd0);
        @(negedge clk); resetb = 1'b1;
        @(posedge clk); #1;
        idle("idle0"); idle("idle1");

        // Flat field
        cur_en = 1'b1; cur_pat = 2'd0;
        tok(c_FS, 16'h0, "ff.fs"); tok(c_RS, 16'h0, "ff.rs");
        px(k_flat, rgb(512, 512, 512), "ff.p00");
        px(k_flat, rgb(512, 512, 512), "ff.p01");
        tok(c_RE, 16'h0, "ff.re"); tok(c_RS, 16'h0, "ff.rs1");
        px(k_flat, rgb(512, 512, 512), "ff.p10");
        idle("ff.gap");
        px(k_flat, rgb(512, 512, 512), "ff.p11");
        tok(c_RE, 16'h0, "ff.re1"); tok(c_FE, 16'h0, "ff.fe");

        // Site decode, pattern R at (0,0)
        tok(c_FS, 16'h0, "sd.fs"); tok(c_RS, 16'h0, "sd.rs");
        px(k_19, rgb(5, 5, 5),   "sd.R");
        px(k_a,  rgb(30, 7, 5),  "sd.Gr");
        tok(c_RE, 16'h0, "sd.re"); tok(c_RS, 16'h0, "sd.rs1");
        px(k_a,  rgb(5, 7, 30),  "sd.Gb");
        px(k_c,  rgb(8, 5, 5),   "sd.B");
        tok(c_RE, 16'h0, "sd.re1"); tok(c_FE, 16'h0, "sd.fe");

        // Rounding and max code
        cur_pat = 2'd1;
        tok(c_FS, 16'h0, "rd.fs"); tok(c_RS, 16'h0, "rd.rs");
        px(k_r1, rgb(1, 3, 0), "rd.avg2");
        tok(c_RE, 16'h0, "rd.re"); tok(c_FE, 16'h0, "rd.fe");
        cur_pat = 2'd0;
        tok(c_FS, 16'h0, "rd.fs1"); tok(c_RS, 16'h0, "rd.rs1");
        px(k_e1, rgb(9, 0, 0), "rd.avg4lo");
        tok(c_RE, 16'h0, "rd.re1"); tok(c_FE, 16'h0, "rd.fe1");
        tok(c_FS, 16'h0, "rd.fs2"); tok(c_RS, 16'h0, "rd.rs2");
        px(k_e2,  rgb(9, 1, 0),          "rd.avg4up");
        px(k_max, rgb(1023, 1023, 1023), "rd.maxGr");
        tok(c_RE, 16'h0, "rd.re2"); tok(c_RS, 16'h0, "rd.rs3");
        px(k_max, rgb(1023, 1023, 1023), "rd.maxGb");
        px(k_max, rgb(1023, 1023, 1023), "rd.maxB");
        tok(c_RE, 16'h0, "rd.re3"); tok(c_FE, 16'h0, "rd.fe2");

        // Pattern latched at FRAME_START only
        cur_pat = 2'd3;
        tok(c_FS, 16'h0, "pl.fs");
        cur_pat = 2'd0;
        tok(c_RS, 16'h0, "pl.rs");
        px(k_c, rgb(8, 5, 5),  "pl.B");
        px(k_a, rgb(5, 7, 30), "pl.Gb");
        tok(c_RE, 16'h0, "pl.re"); tok(c_FE, 16'h0, "pl.fe");
        tok(c_FS, 16'h0, "pl.fs1"); tok(c_RS, 16'h0, "pl.rs1");
        px(k_a, rgb(7, 18, 0), "pl.R");
        tok(c_RE, 16'h0, "pl.re1"); tok(c_RS, 16'h0, "pl.rs2");
        px(k_a, rgb(5, 7, 30), "pl.oddrowGb");
        tok(c_RE, 16'h0, "pl.re2"); tok(c_FE, 16'h0, "pl.fe1");

        // Bypass with headers and gaps
        cur_en = 1'b0;
        tok(c_FS, 16'hA000, "bp.fs");
        tok(c_HD, 16'h1111, "bp.h0");
        tok(c_HD, 16'h2222, "bp.h1");
        idle("bp.gap0");
        tok(c_HD, 16'h3333, "bp.h2");
        tok(c_HD, 16'h4444, "bp.h3");
        tok(c_RS, 16'h0, "bp.rs");
        px(k_a, rgb(7, 7, 7), "bp.p0");
        idle("bp.gap1"); idle("bp.gap2");
        px(k_c, rgb(5, 5, 5), "bp.p1");
        idle("bp.gap3");
        tok(c_RE, 16'h0, "bp.re"); tok(c_FE, 16'hBEEF, "bp.fe");
        idle("bp.flush");

        // Asynchronous reset in the middle of a pixel stream
        cur_en = 1'b1;
        tok(c_FS, 16'h0, "ar.fs"); tok(c_RS, 16'h0, "ar.rs");
        px(k_a, rgb(7, 18, 0), "ar.p0");
        px(k_a, rgb(30, 7, 5), "ar.p1");
        #2;
        resetb = 1'b0;
        dvi = 1'b0; dtypei = '0; kernel_datai = '0; meta_datai = '0;
        #1;
        chk("ar.async.dvo",   64'(dvo),        64'd0);
        chk("ar.async.dtype", 64'(dtypeo),     64'd0);
        chk("ar.async.meta",  64'(meta_datao), 64'd0);
        chk("ar.async.data",  64'(datao),      64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("ar.held.dvo", 64'(dvo), 64'd0);
        @(negedge clk); resetb = 1'b1;
        @(posedge clk); #1;
        chk("ar.release.dvo", 64'(dvo), 64'd0);
        p_armed = 1'b1; p_dvo = 1'b0; p_dt = '0; p_meta = '0; p_data = '0; p_tag = "ar.quiet";
        tok(c_FS, 16'h5A5A, "ar.fs1"); tok(c_RS, 16'h0, "ar.rs1");
        px(k_a, rgb(7, 18, 0), "ar.p2");
        tok(c_RE, 16'h0, "ar.re"); tok(c_FE, 16'h0, "ar.fe");
        idle("ar.flush0"); idle("ar.flush1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
